// File: rtl/module_regfile_arbiter_pkg.sv
// module_regfile_arbiter_pkg: shared register-file geometry and arbiter state encoding
package rf_pkg;
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int RF_DEPTH = 32;
    typedef enum logic {IDLE, CLEAR} arb_state_e;
endpackage

// File: rtl/module_regfile_arbiter_if.sv
// module_regfile_arbiter_if: client and register-file signals around the arbiter
// Ports (slave = arbiter side):
//   in  wb_we_i/wb_a_i/wb_wd_i     writeback write request
//   in  dec_a1_i                   decode read address for port 1
//   in  dbg_valid_i/we_i/a_i/wd_i  debug request; out dbg_ready_o, dbg_rvalid_o, dbg_rd_o
//   in  clr_req_i; out clr_busy_o  clear sequencer
//   out stall_o                    pipeline freeze
//   out rf_we3_o/rf_a3_o/rf_wd3_o  register-file write port
//   out rf_a1_o; in rf_rd1_i       register-file read port 1
interface module_regfile_arbiter_if;
    import rf_pkg::*;
    logic             wb_we_i;
    logic [RF_AW-1:0] wb_a_i;
    logic [RF_DW-1:0] wb_wd_i;
    logic [RF_AW-1:0] dec_a1_i;
    logic             dbg_valid_i;
    logic             dbg_we_i;
    logic [RF_AW-1:0] dbg_a_i;
    logic [RF_DW-1:0] dbg_wd_i;
    logic             dbg_ready_o;
    logic             dbg_rvalid_o;
    logic [RF_DW-1:0] dbg_rd_o;
    logic             clr_req_i;
    logic             clr_busy_o;
    logic             stall_o;
    logic             rf_we3_o;
    logic [RF_AW-1:0] rf_a3_o;
    logic [RF_DW-1:0] rf_wd3_o;
    logic [RF_AW-1:0] rf_a1_o;
    logic [RF_DW-1:0] rf_rd1_i;
    modport slave (
        input  wb_we_i, wb_a_i, wb_wd_i, dec_a1_i, dbg_valid_i, dbg_we_i, dbg_a_i, dbg_wd_i,
               clr_req_i, rf_rd1_i,
        output dbg_ready_o, dbg_rvalid_o, dbg_rd_o, clr_busy_o, stall_o,
               rf_we3_o, rf_a3_o, rf_wd3_o, rf_a1_o
    );
    modport master (
        output wb_we_i, wb_a_i, wb_wd_i, dec_a1_i, dbg_valid_i, dbg_we_i, dbg_a_i, dbg_wd_i,
               clr_req_i, rf_rd1_i,
        input  dbg_ready_o, dbg_rvalid_o, dbg_rd_o, clr_busy_o, stall_o,
               rf_we3_o, rf_a3_o, rf_wd3_o, rf_a1_o
    );
endinterface

// File: rtl/module_regfile_arbiter_starve_counter.sv
// module_starve_counter: saturating wait counter with clear
// Ports: clk_i, rst_i (sync, active high); inc_i count one waiting cycle;
//        clr_i return to zero (wins over inc_i); full_o counter has reached STARVE_MAX
module module_starve_counter #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic full_o
);
    localparam int CW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign full_o = cnt_q == CW'(STARVE_MAX);
    assign cnt_d = clr_i ? '0 : (inc_i && !full_o) ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/module_regfile_arbiter.sv
// module_regfile_arbiter: shares the register-file write port and read port 1 between WB, debug and clear
// Ports: clk_i, rst_i (sync, active high); bus (slave modport) carries the writeback,
//        decode, debug handshake, clear request, stall and register-file port signals.
// Parameter STARVE_MAX: cycles a debug write may wait before it is forced through with a stall.
module module_regfile_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    module_regfile_arbiter_if.slave  bus
);
    arb_state_e       state_q, state_d;
    logic [RF_AW-1:0] idx_q, idx_d;
    logic             busy_q, rvalid_q;
    logic [RF_DW-1:0] rd_q, rd_d;
    logic             idle, avail, dbg_wr, starve_full;
    logic             clear_wr, rd_gnt, force_gnt, wr_gnt, stall;
    assign idle = state_q == IDLE;
    // A debug or WB grant is only possible in IDLE when no clear is starting
    assign avail = !rst_i && idle && !bus.clr_req_i;
    assign dbg_wr = bus.dbg_valid_i && bus.dbg_we_i;
    module_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (dbg_wr && !bus.dbg_ready_o),
        .clr_i  (!bus.dbg_valid_i || bus.dbg_ready_o),
        .full_o (starve_full)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= RF_AW'(1);
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_q   <= clear_wr;
            rvalid_q <= rd_gnt;
            rd_q     <= rd_d;
        end
    end
    // The request cycle itself already writes x1, so CLEAR covers x2..x31
    always_comb begin
        state_d = !idle ? (idx_q == RF_AW'(RF_DEPTH - 1) ? IDLE : CLEAR) : (bus.clr_req_i ? CLEAR : IDLE);
        idx_d = !clear_wr ? idx_q : idx_q == RF_AW'(RF_DEPTH - 1) ? RF_AW'(1) : idx_q + RF_AW'(1);
        rd_d = !rd_gnt ? rd_q : bus.dbg_a_i == '0 ? '0 : bus.rf_rd1_i;
    end
    always_comb begin
        clear_wr  = !rst_i && (!idle || bus.clr_req_i);
        rd_gnt    = avail && bus.dbg_valid_i && !bus.dbg_we_i;
        force_gnt = avail && dbg_wr && starve_full;
        wr_gnt    = force_gnt || (avail && dbg_wr && !bus.wb_we_i);
        stall     = clear_wr || rd_gnt || force_gnt;
        bus.stall_o      = stall;
        bus.dbg_ready_o  = rd_gnt || wr_gnt;
        bus.rf_a3_o      = clear_wr ? idx_q : wr_gnt ? bus.dbg_a_i : bus.wb_a_i;
        bus.rf_wd3_o     = clear_wr ? '0 : wr_gnt ? bus.dbg_wd_i : bus.wb_wd_i;
        bus.rf_we3_o     = (clear_wr || wr_gnt || (!rst_i && bus.wb_we_i && !stall)) && bus.rf_a3_o != '0;
        bus.rf_a1_o      = rd_gnt ? bus.dbg_a_i : bus.dec_a1_i;
        bus.clr_busy_o   = busy_q;
        bus.dbg_rvalid_o = rvalid_q;
        bus.dbg_rd_o     = rd_q;
    end
endmodule

// File: tb/tb_module_regfile_arbiter.sv
// tb_module_regfile_arbiter: directed vectors and multi-cycle sequences for the register-file arbiter
module tb_module_regfile_arbiter;
    import rf_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    module_regfile_arbiter_if bus();
    module_regfile_arbiter #(.STARVE_MAX(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    logic [31:0] mem [32];
    always @(negedge clk) if (bus.rf_we3_o && bus.rf_a3_o != 5'd0) mem[bus.rf_a3_o] <= bus.rf_wd3_o;
    assign bus.rf_rd1_i = (bus.rf_a1_o == 5'd0) ? 32'd0 : mem[bus.rf_a1_o];
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic wb_we; logic [4:0] wb_a; logic [31:0] wb_wd; logic [4:0] dec_a1;
        logic dv; logic dwe; logic [4:0] da; logic [31:0] dwd;
        logic we3; logic [4:0] a3; logic [31:0] wd3; logic [4:0] a1;
        logic stall; logic rdy; logic rv; logic [31:0] rd;
    } vec_t;
    vec_t vt [8];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic wbwe, input logic [4:0] wba, input logic [31:0] wbwd,
                         input logic [4:0] dec, input logic dv, input logic dwe,
                         input logic [4:0] da, input logic [31:0] dwd, input logic clr);
        bus.wb_we_i = wbwe; bus.wb_a_i = wba; bus.wb_wd_i = wbwd; bus.dec_a1_i = dec;
        bus.dbg_valid_i = dv; bus.dbg_we_i = dwe; bus.dbg_a_i = da; bus.dbg_wd_i = dwd;
        bus.clr_req_i = clr;
    endtask
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic quiet();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask
    task automatic preload();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'hA500_0000 | 32'(i), 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            next_cycle();
        end
        quiet();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[1] = '{1'b1, 5'd0, 32'h11111111, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h11111111, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[2] = '{1'b0, 5'd9, 32'h0, 5'd3, 1'b1, 1'b1, 5'd7, 32'h1234, 1'b1, 5'd7, 32'h1234, 5'd3, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[3] = '{1'b0, 5'd9, 32'h0, 5'd3, 1'b1, 1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h5555, 5'd3, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[4] = '{1'b1, 5'd9, 32'h99, 5'd3, 1'b1, 1'b0, 5'd7, 32'h0, 1'b0, 5'd9, 32'h99, 5'd7, 1'b1, 1'b1, 1'b1, 32'h1234};
        vt[5] = '{1'b0, 5'd9, 32'h0, 5'd3, 1'b1, 1'b0, 5'd5, 32'h0, 1'b0, 5'd9, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
        vt[6] = '{1'b0, 5'd9, 32'h0, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 32'h0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h0};
        vt[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd12, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd12, 1'b0, 1'b0, 1'b0, 32'h0};
        // reset: active requests must not leak through
        drive(1'b1, 5'd5, 32'h1, 5'd0, 1'b1, 1'b0, 5'd3, 32'd0, 1'b1);
        #2;
        chk("rst we3", 32'(bus.rf_we3_o), 32'd0);
        chk("rst stall", 32'(bus.stall_o), 32'd0);
        chk("rst ready", 32'(bus.dbg_ready_o), 32'd0);
        next_cycle();
        chk("rst busy", 32'(bus.clr_busy_o), 32'd0);
        chk("rst rvalid", 32'(bus.dbg_rvalid_o), 32'd0);
        chk("rst rd", bus.dbg_rd_o, 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].wb_we, vt[i].wb_a, vt[i].wb_wd, vt[i].dec_a1, vt[i].dv, vt[i].dwe, vt[i].da, vt[i].dwd, 1'b0);
            #3;
            chk($sformatf("vec%0d we3", i), 32'(bus.rf_we3_o), 32'(vt[i].we3));
            chk($sformatf("vec%0d a3", i), 32'(bus.rf_a3_o), 32'(vt[i].a3));
            chk($sformatf("vec%0d wd3", i), bus.rf_wd3_o, vt[i].wd3);
            chk($sformatf("vec%0d a1", i), 32'(bus.rf_a1_o), 32'(vt[i].a1));
            chk($sformatf("vec%0d stall", i), 32'(bus.stall_o), 32'(vt[i].stall));
            chk($sformatf("vec%0d ready", i), 32'(bus.dbg_ready_o), 32'(vt[i].rdy));
            next_cycle();
            chk($sformatf("vec%0d rvalid", i), 32'(bus.dbg_rvalid_o), 32'(vt[i].rv));
            if (vt[i].rv) chk($sformatf("vec%0d rd", i), bus.dbg_rd_o, vt[i].rd);
        end
        quiet();
        chk("mem x5", mem[5], 32'hDEADBEEF);
        chk("mem x7", mem[7], 32'h1234);
        chk("mem x31", mem[31], 32'hFFFFFFFF);
        next_cycle();
        // starvation: WB writes every cycle, debug write forced on the 9th cycle
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 5'd3, 32'h300 + 32'(i), 5'd0, 1'b1, 1'b1, 5'd20, 32'hCAFEF00D, 1'b0);
            #3;
            chk($sformatf("starve%0d ready", i), 32'(bus.dbg_ready_o), 32'(i == 9));
            chk($sformatf("starve%0d stall", i), 32'(bus.stall_o), 32'(i == 9));
            chk($sformatf("starve%0d a3", i), 32'(bus.rf_a3_o), i == 9 ? 32'd20 : 32'd3);
            next_cycle();
        end
        quiet();
        chk("starve mem x20", mem[20], 32'hCAFEF00D);
        chk("starve mem x3", mem[3], 32'h308);
        next_cycle();
        // clear with WB and a debug write pending throughout
        preload();
        next_cycle();
        drive(1'b1, 5'd2, 32'hFFFF0000, 5'd0, 1'b1, 1'b1, 5'd4, 32'h44, 1'b1);
        for (int k = 0; k < 31; k++) begin
            #3;
            chk($sformatf("clr%0d we3", k), 32'(bus.rf_we3_o), 32'd1);
            chk($sformatf("clr%0d a3", k), 32'(bus.rf_a3_o), 32'(k + 1));
            chk($sformatf("clr%0d wd3", k), bus.rf_wd3_o, 32'd0);
            chk($sformatf("clr%0d stall", k), 32'(bus.stall_o), 32'd1);
            chk($sformatf("clr%0d ready", k), 32'(bus.dbg_ready_o), 32'd0);
            chk($sformatf("clr%0d busy", k), 32'(bus.clr_busy_o), 32'(k != 0));
            next_cycle();
            bus.clr_req_i = 1'b0;
        end
        #3;
        chk("clr31 busy", 32'(bus.clr_busy_o), 32'd1);
        chk("clr31 ready", 32'(bus.dbg_ready_o), 32'd1);
        chk("clr31 stall", 32'(bus.stall_o), 32'd1);
        chk("clr31 a3", 32'(bus.rf_a3_o), 32'd4);
        chk("clr31 wd3", bus.rf_wd3_o, 32'h44);
        next_cycle();
        quiet();
        #3;
        chk("clr32 busy", 32'(bus.clr_busy_o), 32'd0);
        chk("clr32 stall", 32'(bus.stall_o), 32'd0);
        for (int i = 1; i < 32; i++) chk($sformatf("clr mem x%0d", i), mem[i], i == 4 ? 32'h44 : 32'd0);
        next_cycle();
        // reset in the middle of a clear
        preload();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd5, 32'd0, 1'b0);
        next_cycle();
        chk("pre rvalid", 32'(bus.dbg_rvalid_o), 32'd1);
        chk("pre rd", bus.dbg_rd_o, 32'hA500_0005);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        #3;
        chk("mid a3", 32'(bus.rf_a3_o), 32'd1);
        next_cycle();
        bus.clr_req_i = 1'b0;
        for (int k = 1; k < 9; k++) next_cycle();
        chk("mid busy", 32'(bus.clr_busy_o), 32'd1);
        rst = 1'b1;
        #3;
        chk("mid rst we3", 32'(bus.rf_we3_o), 32'd0);
        chk("mid rst stall", 32'(bus.stall_o), 32'd0);
        chk("mid rst ready", 32'(bus.dbg_ready_o), 32'd0);
        next_cycle();
        rst = 1'b0;
        #3;
        chk("post busy", 32'(bus.clr_busy_o), 32'd0);
        chk("post rvalid", 32'(bus.dbg_rvalid_o), 32'd0);
        chk("post rd", bus.dbg_rd_o, 32'd0);
        chk("post stall", 32'(bus.stall_o), 32'd0);
        chk("post we3", 32'(bus.rf_we3_o), 32'd0);
        for (int i = 1; i < 32; i++) chk($sformatf("mid mem x%0d", i), mem[i], i < 10 ? 32'd0 : 32'hA500_0000 | 32'(i));
        next_cycle();
        drive(1'b1, 5'd6, 32'h66, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        #3;
        chk("idle we3", 32'(bus.rf_we3_o), 32'd1);
        chk("idle a3", 32'(bus.rf_a3_o), 32'd6);
        chk("idle stall", 32'(bus.stall_o), 32'd0);
        next_cycle();
        quiet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
